// File: rtl/control_pipeline_pkg.sv
// Shared types for the ID-stage control pipeline: opcodes, formats,
// branch conditions, the control bundle and the forwarding select.
package control_pipeline_pkg;

  // Register index storage width inside the bundle; ports may be narrower.
  localparam int REG_ADDR_MAX = 8;
  typedef logic [REG_ADDR_MAX-1:0] reg_idx_t;

  typedef enum logic [6:0] {
    OP_LOAD     = 7'b0000011,
    OP_LOAD_FP  = 7'b0000111,
    OP_IMM      = 7'b0010011,
    OP_AUIPC    = 7'b0010111,
    OP_STORE    = 7'b0100011,
    OP_STORE_FP = 7'b0100111,
    OP_OP       = 7'b0110011,
    OP_LUI      = 7'b0110111,
    OP_BRANCH   = 7'b1100011,
    OP_JALR     = 7'b1100111,
    OP_JAL      = 7'b1101111
  } instruction_format_type;

  typedef enum logic [2:0] {
    OPT_R = 3'd0,
    OPT_I = 3'd1,
    OPT_S = 3'd2,
    OPT_B = 3'd3,
    OPT_U = 3'd4,
    OPT_J = 3'd5
  } instruction_op_type;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem2reg;
    logic       mem_write;
    logic       alu_src;
    logic       auipc;
    logic       branch;
    logic       jump;
    logic [2:0] cond;
    logic [2:0] load_size;
    logic [2:0] store_size;
    reg_idx_t   rs1;
    reg_idx_t   rs2;
    reg_idx_t   rd;
    logic       rs1_used;
    logic       rs2_used;
  } ctrl_bundle_t;

  // Nearest producer wins: EX/MEM is younger than MEM/WB.
  function automatic fwd_sel_e fwd_pick(reg_idx_t src, ctrl_bundle_t exmem, ctrl_bundle_t memwb);
    if (exmem.valid && exmem.reg_write && exmem.rd != '0 && exmem.rd == src)
      return FWD_EXMEM;
    else if (memwb.valid && memwb.reg_write && memwb.rd != '0 && memwb.rd == src)
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/control_pipeline_branch_comparator.sv
// Branch condition evaluation on the already-forwarded EX operands.
module branch_comparator
  import control_pipeline_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      cond,
  output logic            taken
);

  // Compare per funct3; reserved encodings never branch.
  always_comb begin
    case (cond)
      BEQ:     taken = (a == b);
      BNE:     taken = (a != b);
      BLT:     taken = ($signed(a) <  $signed(b));
      BGE:     taken = ($signed(a) >= $signed(b));
      BLTU:    taken = (a <  b);
      BGEU:    taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_pipeline.sv
// ID decode into a control bundle, carried through ID/EX, EX/MEM, MEM/WB,
// with EX branch resolution, load-use stall, forwarding selects and a
// retired-instruction counter.
module control_pipeline
  import control_pipeline_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  instruction_format_type id_opcode,
  input  instruction_op_type     id_optype,
  input  logic [2:0]             id_funct3,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic [XLEN-1:0]        ex_rs1_data,
  input  logic [XLEN-1:0]        ex_rs2_data,
  output logic                   stall,
  output logic                   flush,
  output logic                   branch_taken,
  output logic                   ex_alu_src,
  output logic                   ex_auipc,
  output logic                   mem_write,
  output logic [2:0]             mem_load_size,
  output logic [2:0]             mem_store_size,
  output logic                   wb_reg_write,
  output logic                   wb_mem2reg,
  output logic [REG_ADDR_W-1:0]  wb_rd,
  output fwd_sel_e               fwd_a_sel,
  output fwd_sel_e               fwd_b_sel,
  output logic [CNT_W-1:0]       instret
);

  ctrl_bundle_t dec, idex, exmem, memwb;
  logic         cmp_taken;
  logic         hazard;

  // Decode the ID fields; unknown formats and invalid slots decode to zero.
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.rs1   = reg_idx_t'(id_rs1);
    dec.rs2   = reg_idx_t'(id_rs2);
    dec.rd    = reg_idx_t'(id_rd);
    case (id_optype)
      OPT_R: begin
        dec.reg_write = 1'b1;
        dec.rs1_used  = 1'b1;
        dec.rs2_used  = 1'b1;
      end
      OPT_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.rs1_used  = 1'b1;
        if (id_opcode == OP_LOAD || id_opcode == OP_LOAD_FP) begin
          dec.mem2reg   = 1'b1;
          dec.load_size = id_funct3;
        end
      end
      OPT_S: begin
        dec.alu_src    = 1'b1;
        dec.mem_write  = 1'b1;
        dec.store_size = id_funct3;
        dec.rs1_used   = 1'b1;
        dec.rs2_used   = 1'b1;
      end
      OPT_B: begin
        dec.branch   = 1'b1;
        dec.cond     = id_funct3;
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
      end
      OPT_U: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.auipc     = (id_opcode == OP_AUIPC);
      end
      OPT_J: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: dec = '0;
    endcase
    if (!id_valid) dec = '0;
  end

  branch_comparator #(.XLEN(XLEN)) u_bcmp (
    .a     (ex_rs1_data),
    .b     (ex_rs2_data),
    .cond  (idex.cond),
    .taken (cmp_taken)
  );

  assign branch_taken = idex.valid & (idex.jump | (idex.branch & cmp_taken));
  assign flush        = branch_taken;

  // A load in EX whose rd feeds the instruction in ID cannot be forwarded in time.
  assign hazard = idex.valid & idex.mem2reg & (idex.rd != '0) & id_valid &
                  ((dec.rs1_used & (dec.rs1 == idex.rd)) |
                   (dec.rs2_used & (dec.rs2 == idex.rd)));
  assign stall  = hazard & ~flush;

  assign fwd_a_sel = fwd_pick(idex.rs1, exmem, memwb);
  assign fwd_b_sel = fwd_pick(idex.rs2, exmem, memwb);

  assign ex_alu_src     = idex.alu_src;
  assign ex_auipc       = idex.auipc;
  assign mem_write      = exmem.mem_write;
  assign mem_load_size  = exmem.load_size;
  assign mem_store_size = exmem.store_size;
  assign wb_reg_write   = memwb.reg_write;
  assign wb_mem2reg     = memwb.mem2reg;
  assign wb_rd          = REG_ADDR_W'(memwb.rd);

  // Advance the pipeline; stall/flush only bubble ID/EX, later stages always move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      idex  <= (flush | stall) ? '0 : dec;
      exmem <= idex;
      memwb <= exmem;
    end
  end

  // Count every valid bundle leaving MEM/WB; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           instret <= '0;
    else if (memwb.valid) instret <= instret + CNT_W'(1);
  end

endmodule
